// File: rtl/soc_bus_pkg.sv
// Shared bus definitions for the instruction-side fabric: bridge state encoding,
// the data word returned on a fetch error, and the address regions the decoder uses.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } instr_bridge_state_e;

  localparam logic [31:0] INSTR_ERR_RDATA = 32'h0000_0000;

  // Compared against address bits [31:20]
  localparam logic [11:0] ROM_REGION  = 12'h000;
  localparam logic [11:0] IRAM_REGION = 12'h001;

endpackage

// File: rtl/obi_axi_instr_bridge.sv
// CV32E40P OBI instruction fetch to single-outstanding AXI-Lite read master.
// Define INSTR_BRIDGE_TIMEOUT_EN to turn fetches that never get an R beat into OBI error responses.
module obi_axi_instr_bridge
  import soc_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  output logic        m_rready
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("obi_axi_instr_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  instr_bridge_state_e r_state;
  logic [31:0]         r_araddr;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic                w_expire;
  logic                w_finish;

`ifdef INSTR_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Expires on the edge where the count would reach TIMEOUT_CYCLES; a real beat wins.
  assign w_expire = (r_state == RESP) && !m_rvalid &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ADDR && m_arready) begin
        r_cnt <= '0;
      end else if (r_state == RESP && !m_rvalid && !w_expire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == RESP && m_rvalid) begin
        r_err <= 1'b0;
      end else if (w_expire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign instr_err_o = r_err;
`else
  assign w_expire    = 1'b0;
  assign instr_err_o = 1'b0;
`endif

  assign w_finish = (r_state == RESP) && (m_rvalid || w_expire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rready <= 1'b1;
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_req_i) begin
            r_araddr  <= {instr_addr_i[31:2], 2'b00};
            r_arvalid <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          // R beats seen here belong to no open fetch and are dropped.
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (w_finish) begin
            r_rvalid <= 1'b1;
            r_rdata  <= m_rvalid ? m_rdata : INSTR_ERR_RDATA;
            if (instr_req_i) begin
              r_araddr  <= {instr_addr_i[31:2], 2'b00};
              r_arvalid <= 1'b1;
              r_state   <= ADDR;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign instr_gnt_o    = r_arvalid && m_arready;
  assign instr_rvalid_o = r_rvalid;
  assign instr_rdata_o  = r_rdata;
  assign m_araddr       = r_araddr;
  assign m_arvalid      = r_arvalid;
  assign m_rready       = r_rready;

endmodule
